// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART transmit arbiter: state encoding, byte width
// and a small index helper used by the round-robin pointer update.
package uart_tx_arbiter_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD      = 3'd1,
        ST_SEND      = 3'd2,
        ST_WAIT_LOW  = 3'd3,
        ST_WAIT_HIGH = 3'd4
    } arb_state_t;

    function automatic int next_index(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_picker.sv
// Combinational round-robin picker: first requester at or after rr_ptr,
// wrapping modulo N_REQ, returned both one-hot and as an index.
module rr_picker #(
    parameter int N_REQ = 4,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic [N_REQ-1:0] winner,
    output logic [IDX_W-1:0] winner_idx
);

    logic             found;
    logic [IDX_W-1:0] sel;

    always_comb begin
        winner     = '0;
        winner_idx = '0;
        found      = 1'b0;
        sel        = '0;
        for (int off = 0; off < N_REQ; off++) begin
            sel = IDX_W'((int'(rr_ptr) + off) % N_REQ);
            if (!found && req[sel]) begin
                found       = 1'b1;
                winner[sel] = 1'b1;
                winner_idx  = sel;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter and byte sequencer sharing one uart_tx_8n1 between N_REQ
// message sources. Optional byte watchdog is built when UART_ARB_TIMEOUT_EN is defined.
//
// state        | meaning
// ST_IDLE      | no owner; grant only when a request is pending and the UART is idle
// ST_LOAD      | latch the owner's byte and last flag, acknowledge the source
// ST_SEND      | one-cycle senddata pulse to the transmitter
// ST_WAIT_LOW  | wait for txdone to fall (byte accepted)
// ST_WAIT_HIGH | wait for txdone to rise (byte finished), then next byte or release
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int N_REQ          = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        req,
    input  logic [BYTE_W*N_REQ-1:0] data,
    input  logic [N_REQ-1:0]        last,
    output logic [N_REQ-1:0]        ack,
    output logic [N_REQ-1:0]        grant,
    output logic [BYTE_W-1:0]       uart_txbyte,
    output logic                    uart_send,
    input  logic                    uart_txdone,
    output logic                    busy,
    output logic                    timeout_err
);

    localparam int IDX_W = $clog2(N_REQ);

    if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("uart_tx_arbiter: N_REQ must be 2..8 and TIMEOUT_CYCLES >= 1");
    end

    arb_state_t       state;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] w_q;
    logic             last_q;
    logic [N_REQ-1:0] pick;
    logic [IDX_W-1:0] pick_idx;
    logic [IDX_W-1:0] ptr_after_w;

    rr_picker #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_picker (
        .req        (req),
        .rr_ptr     (rr_ptr),
        .winner     (pick),
        .winner_idx (pick_idx)
    );

    assign ptr_after_w = IDX_W'(next_index(int'(w_q), N_REQ));

`ifdef UART_ARB_TIMEOUT_EN
    localparam int               WD_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0]  WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
    logic [WD_W-1:0] wdog;
`else
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            grant       <= '0;
            ack         <= '0;
            uart_send   <= 1'b0;
            uart_txbyte <= '0;
            busy        <= 1'b0;
            rr_ptr      <= '0;
            w_q         <= '0;
            last_q      <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
            wdog        <= '0;
            timeout_err <= 1'b0;
`endif
        end else begin
            ack       <= '0;
            uart_send <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
            timeout_err <= 1'b0;
`endif
            case (state)
                ST_IDLE: begin
                    // A reset can land mid-byte; never start while the UART is still shifting.
                    if (|req && uart_txdone) begin
                        grant <= pick;
                        w_q   <= pick_idx;
                        busy  <= 1'b1;
                        state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    uart_txbyte <= data[int'(w_q)*BYTE_W +: BYTE_W];
                    last_q      <= last[w_q];
                    ack         <= grant;
                    state       <= ST_SEND;
                end
                ST_SEND: begin
                    uart_send <= 1'b1;
                    state     <= ST_WAIT_LOW;
`ifdef UART_ARB_TIMEOUT_EN
                    wdog      <= '0;
`endif
                end
                ST_WAIT_LOW: begin
                    if (!uart_txdone) begin
                        state <= ST_WAIT_HIGH;
                    end
                end
                ST_WAIT_HIGH: begin
                    if (uart_txdone) begin
                        // An abandoned message releases exactly like a finished one.
                        if (last_q || !req[w_q]) begin
                            grant  <= '0;
                            busy   <= 1'b0;
                            rr_ptr <= ptr_after_w;
                            state  <= ST_IDLE;
                        end else begin
                            state <= ST_LOAD;
                        end
                    end
                end
                default: begin
                    grant <= '0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
`ifdef UART_ARB_TIMEOUT_EN
            // Watchdog overrides any transition taken in the same cycle.
            if (state == ST_WAIT_LOW || state == ST_WAIT_HIGH) begin
                if (wdog == WD_LAST) begin
                    timeout_err <= 1'b1;
                    grant       <= '0;
                    busy        <= 1'b0;
                    rr_ptr      <= ptr_after_w;
                    state       <= ST_IDLE;
                    wdog        <= '0;
                end else begin
                    wdog <= wdog + 1'b1;
                end
            end
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter with a simple 8-cycle UART model
// and four scripted message sources.
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [3:0]  req = '0;
    logic [31:0] data = '0;
    logic [3:0]  last = '0;
    logic [3:0]  ack;
    logic [3:0]  grant;
    logic [7:0]  uart_txbyte;
    logic        uart_send;
    logic        uart_txdone = 1'b1;
    logic        busy;
    logic        timeout_err;

    uart_tx_arbiter #(
        .N_REQ          (4),
        .TIMEOUT_CYCLES (64)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .data        (data),
        .last        (last),
        .ack         (ack),
        .grant       (grant),
        .uart_txbyte (uart_txbyte),
        .uart_send   (uart_send),
        .uart_txdone (uart_txdone),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    logic [7:0] mem [4][8];
    logic       mlast [4][8];
    int         cnt [4];
    int         pos [4];

    logic [7:0] send_byte [64];
    int         send_src [64];
    int         send_cyc [64];
    int         n_send;
    int         grant_log [16];
    int         n_grant;
    int         ack_cnt [4];
    int         first_ack_cyc, first_grant_cyc, ack_total;
    int         grant_fall_cyc, txrise_cyc;
    int         te_cnt, te_cyc;
    bit         model_en = 1'b1;
    logic       manual_txdone = 1'b1;
    int         ucnt = 0;
    logic [3:0] prev_grant = '0;

    function automatic int oh2idx(input logic [3:0] g);
        for (int i = 0; i < 4; i++) if (g[i]) return i;
        return -1;
    endfunction

    // Monitor, source scripts and UART model all act on the falling edge.
    always @(negedge clk) begin
        logic txd;
        if (grant != prev_grant && grant != '0) begin
            if (n_grant == 0) first_grant_cyc = cyc;
            if (n_grant < 16) grant_log[n_grant] = oh2idx(grant);
            n_grant++;
        end
        if (grant == '0 && prev_grant != '0) grant_fall_cyc = cyc;
        prev_grant = grant;
        for (int i = 0; i < 4; i++) begin
            if (ack[i]) begin
                if (ack_total == 0) first_ack_cyc = cyc;
                ack_total++;
                ack_cnt[i]++;
                pos[i]++;
            end
        end
        if (uart_send) begin
            if (n_send < 64) begin
                send_byte[n_send] = uart_txbyte;
                send_src[n_send]  = oh2idx(grant);
                send_cyc[n_send]  = cyc;
            end
            n_send++;
        end
        if (timeout_err) begin
            te_cnt++;
            te_cyc = cyc;
        end
        if (model_en) begin
            if (uart_send) ucnt = 8;
            else if (ucnt > 0) ucnt--;
            txd = (ucnt == 0);
        end else begin
            txd = manual_txdone;
        end
        if (!uart_txdone && txd) txrise_cyc = cyc;
        uart_txdone = txd;
        for (int i = 0; i < 4; i++) begin
            if (pos[i] < cnt[i]) begin
                req[i]         = 1'b1;
                data[8*i +: 8] = mem[i][pos[i]];
                last[i]        = mlast[i][pos[i]];
            end else begin
                req[i]         = 1'b0;
                data[8*i +: 8] = 8'h00;
                last[i]        = 1'b0;
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic push(input int s, input logic [7:0] b, input logic l);
        mem[s][cnt[s]]   = b;
        mlast[s][cnt[s]] = l;
        cnt[s]++;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_en = 1'b1;
        manual_txdone = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cnt[i] = 0;
            pos[i] = 0;
            ack_cnt[i] = 0;
        end
        n_send = 0;
        n_grant = 0;
        ack_total = 0;
        te_cnt = 0;
        tick_n(3);
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout: got no finish, want finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int exp_src [4];
        logic [7:0] exp_b [4];
        int s0;

        // Reset values
        #3 rst_n = 1'b0;
        #1;
        check_val("rst_grant", grant, 0);
        check_val("rst_ack", ack, 0);
        check_val("rst_send", uart_send, 0);
        check_val("rst_txbyte", uart_txbyte, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_timeout", timeout_err, 0);
        do_reset();

        // Single source "OK\n"
        push(0, 8'h4F, 1'b0);
        push(0, 8'h4B, 1'b0);
        push(0, 8'h0A, 1'b1);
        for (int i = 0; i < 300 && !(n_send == 3 && grant == '0 && busy == 1'b0); i++) tick();
        check_val("t1_done", (n_send == 3 && grant == '0 && busy == 1'b0), 1);
        check_val("t1_byte0", send_byte[0], 8'h4F);
        check_val("t1_byte1", send_byte[1], 8'h4B);
        check_val("t1_byte2", send_byte[2], 8'h0A);
        check_val("t1_acks", ack_cnt[0], 3);
        check_val("t1_ack_lat", first_ack_cyc - first_grant_cyc, 1);
        check_val("t1_send_lat", send_cyc[0] - first_grant_cyc, 2);
        check_val("t1_byte_gap", send_cyc[1] - send_cyc[0], 11);
        check_val("t1_grants", n_grant, 1);

        // Contention between sources 1 and 2, then rr_ptr must sit at 3
        do_reset();
        push(1, 8'h11, 1'b0);
        push(1, 8'h12, 1'b1);
        push(2, 8'h21, 1'b0);
        push(2, 8'h22, 1'b1);
        for (int i = 0; i < 300 && !(n_send == 4 && grant == '0 && busy == 1'b0); i++) tick();
        check_val("t2_done", (n_send == 4 && grant == '0 && busy == 1'b0), 1);
        exp_src = '{1, 1, 2, 2};
        exp_b   = '{8'h11, 8'h12, 8'h21, 8'h22};
        for (int i = 0; i < 4; i++) begin
            check_val($sformatf("t2_src%0d", i), send_src[i], exp_src[i]);
            check_val($sformatf("t2_byte%0d", i), send_byte[i], exp_b[i]);
        end
        push(0, 8'h30, 1'b1);
        push(3, 8'h33, 1'b1);
        for (int i = 0; i < 300 && !(n_send == 6 && grant == '0 && busy == 1'b0); i++) tick();
        check_val("t2b_done", n_send, 6);
        check_val("t2b_first_src", send_src[4], 3);
        check_val("t2b_first_byte", send_byte[4], 8'h33);
        check_val("t2b_second_src", send_src[5], 0);

        // Fairness with all four sources requesting continuously
        do_reset();
        for (int i = 0; i < 4; i++) begin
            push(i, 8'hA0 + 8'(i), 1'b1);
            push(i, 8'hB0 + 8'(i), 1'b1);
        end
        for (int i = 0; i < 600 && !(n_send == 8 && grant == '0 && busy == 1'b0); i++) tick();
        check_val("t3_done", n_send, 8);
        exp_src = '{0, 1, 2, 3};
        for (int i = 0; i < 4; i++)
            check_val($sformatf("t3_order%0d", i), grant_log[i], exp_src[i]);
        check_val("t3_order4", grant_log[4], 0);
        check_val("t3_byte4", send_byte[4], 8'hB0);

        // Source 3 abandons its message after the first byte
        do_reset();
        push(3, 8'h55, 1'b0);
        for (int i = 0; i < 300 && !(n_send >= 1 && grant == '0 && busy == 1'b0); i++) tick();
        check_val("t4_done", (n_send >= 1 && grant == '0 && busy == 1'b0), 1);
        check_val("t4_byte", send_byte[0], 8'h55);
        check_val("t4_release", grant_fall_cyc - txrise_cyc, 1);
        tick_n(20);
        check_val("t4_no_more_send", n_send, 1);

        // Reset landing mid-byte
        do_reset();
        model_en = 1'b0;
        push(0, 8'h77, 1'b1);
        for (int i = 0; i < 100 && n_send < 1; i++) tick();
        check_val("t5_first_send", n_send, 1);
        manual_txdone = 1'b0;
        tick_n(4);
        check_val("t5_busy_before", busy, 1);
        rst_n = 1'b0;
        #1;
        check_val("t5_rst_grant", grant, 0);
        check_val("t5_rst_busy", busy, 0);
        check_val("t5_rst_txbyte", uart_txbyte, 0);
        push(0, 8'h78, 1'b1);
        tick_n(2);
        rst_n = 1'b1;
        tick_n(10);
        check_val("t5_held_send", n_send, 1);
        check_val("t5_held_grant", grant, 0);
        manual_txdone = 1'b1;
        for (int i = 0; i < 100 && n_send < 2; i++) tick();
        check_val("t5_second_send", n_send, 2);
        check_val("t5_second_byte", send_byte[1], 8'h78);
        check_val("t5_send_after_rise", send_cyc[1] - txrise_cyc, 3);

        // Watchdog: txdone never falls after a send
        do_reset();
        model_en = 1'b0;
        push(1, 8'h61, 1'b1);
        push(2, 8'h62, 1'b1);
        for (int i = 0; i < 100 && n_send < 1; i++) tick();
        check_val("t6_first_send", n_send, 1);
        s0 = send_cyc[0];
`ifdef UART_ARB_TIMEOUT_EN
        for (int i = 0; i < 200 && te_cnt < 1; i++) tick();
        check_val("t6_timeout_seen", te_cnt, 1);
        check_val("t6_timeout_lat", te_cyc - s0, 64);
        check_val("t6_grant_clear", grant, 0);
        for (int i = 0; i < 100 && n_send < 2; i++) tick();
        check_val("t6_next_served", send_src[1], 2);
        check_val("t6_next_byte", send_byte[1], 8'h62);
`else
        tick_n(100);
        check_val("t6_no_timeout", te_cnt, 0);
        check_val("t6_still_busy", busy, 1);
        check_val("t6_still_granted", grant, 4'b0010);
        check_val("t6_first_byte", send_byte[0], 8'h61);
`endif
        do_reset();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
